// File: rtl/uart_rx_os_pkg.sv
// Shared definitions for the oversampling UART receiver and its TX successor.
//   rx_state_e : receive FSM states
//   rx_flags_t : per-word error flags stored alongside the data in the RX FIFO
//   calc_div   : rounded clk ticks per oversample tick
package uart_rx_os_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
  } rx_flags_t;

  localparam int unsigned FLAGS_W = 2;

  // (f_clk + f_tick/2) / f_tick, with f_tick = bps * oversample
  function automatic int unsigned calc_div(input int unsigned clk_mhz,
                                           input int unsigned bps,
                                           input int unsigned os);
    longint unsigned f_hz;
    longint unsigned den;
    f_hz = 64'(clk_mhz) * 64'd1000000;
    den  = 64'(bps) * 64'(os);
    return 32'((f_hz + den / 64'd2) / den);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO for received words.
//   clk, rst_n : clock, synchronous active-low reset (clears entries)
//   push, wdata: write request and word
//   ready      : consumer accepts head; pop = valid && ready
//   valid/head : head entry present / head entry
//   count      : stored words
//   drop       : 1-cycle pulse when a push is lost because the FIFO is full
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_n;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full  = (count == CW'(DEPTH));
  assign pop   = valid & ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign head  = mem[rd_ptr];

  // Occupancy update
  always_comb begin
    count_n = count;
    unique case ({wr_en, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // Storage, pointers (wrap naturally at power-of-2 depth) and status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      drop   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_n;
      valid <= (count_n != '0);
      drop  <= push & full & ~pop;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote and RX FIFO.
//   clk_sys, rst_n     : clock, synchronous active-low reset
//   rx                 : asynchronous serial input, idles high
//   out_valid/out_ready: FIFO head handshake toward host logic
//   out_data           : head word, LSB = first bit received
//   out_parity_err     : head word failed parity (0 when parity disabled)
//   out_frame_err      : head word saw a 0 in a stop bit
//   overrun            : 1-cycle pulse when a completed word is dropped
//   rx_busy            : receive FSM not idle
//   fifo_count         : stored words
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CLK_FREQ    = 50,
  parameter int unsigned BPS         = 115200,
  parameter int unsigned PARITY_ON   = 0,
  parameter int unsigned PARITY_TYPE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk_sys,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_parity_err,
  output logic                          out_frame_err,
  output logic                          overrun,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BPS, OVERSAMPLE);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned M   = OVERSAMPLE / 2;
  localparam int unsigned BW  = $clog2(DATA_WIDTH);
  localparam int unsigned FW  = DATA_WIDTH + FLAGS_W;

  rx_state_e             state;
  rx_state_e             state_n;
  logic                  sync1;
  logic                  rx_s;
  logic                  rx_d;
  logic [TW-1:0]         tcnt;
  logic [SW-1:0]         s;
  logic                  v_lo;
  logic                  v_mid;
  logic [BW-1:0]         bcnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  tick;
  logic                  decide;
  logic                  bit_val;
  logic                  start_edge;
  logic                  restart;
  logic                  push;
  rx_flags_t             push_flags;
  rx_flags_t             head_flags;
  logic [FW-1:0]         head;

  assign tick       = (tcnt == TW'(DIV - 1));
  assign decide     = tick & (s == SW'(M + 1));
  // Samples at M-1 and M are held; the third is the live line at M+1.
  assign bit_val    = (v_lo & v_mid) | (v_lo & rx_s) | (v_mid & rx_s);
  // Edge-triggered start: a line held low after a framing error (break)
  // never produces a new falling edge, so the receiver waits in IDLE.
  assign start_edge = rx_d & ~rx_s;

  // Next-state and frame control
  always_comb begin
    state_n = state;
    restart = 1'b0;
    push    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_n = ST_START;
          restart = 1'b1;
        end
      end
      ST_START: begin
        if (decide) state_n = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide && bcnt == BW'(DATA_WIDTH - 1))
          state_n = (PARITY_ON != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (decide) state_n = ST_STOP;
      end
      ST_STOP: begin
        // Leaving mid-stop-bit lets an early next start edge resync.
        if (decide && stop_cnt == 1'(STOP_BITS - 1)) begin
          state_n = ST_IDLE;
          push    = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Synchroniser, FSM state and busy flag
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      state   <= ST_IDLE;
      rx_busy <= 1'b0;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      rx_d    <= rx_s;
      state   <= state_n;
      rx_busy <= (state_n != ST_IDLE);
    end
  end

  // Tick divider and in-bit sample counter; realigned on each start edge
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      tcnt  <= '0;
      s     <= '0;
      v_lo  <= 1'b0;
      v_mid <= 1'b0;
    end else begin
      if (restart) begin
        tcnt <= '0;
        s    <= '0;
      end else if (tick) begin
        tcnt <= '0;
        s    <= (s == SW'(OVERSAMPLE - 1)) ? '0 : s + SW'(1);
      end else begin
        tcnt <= tcnt + TW'(1);
      end
      if (tick && s == SW'(M - 1)) v_lo  <= rx_s;
      if (tick && s == SW'(M))     v_mid <= rx_s;
    end
  end

  // Frame datapath: data shift, parity and stop checks
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      bcnt     <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else if (restart) begin
      bcnt     <= '0;
      stop_cnt <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else if (decide) begin
      unique case (state)
        ST_DATA: begin
          shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
          bcnt  <= bcnt + BW'(1);
        end
        ST_PARITY: perr_q <= ((^shreg) ^ bit_val) != 1'(PARITY_TYPE);
        ST_STOP: begin
          if (!bit_val) ferr_q <= 1'b1;
          stop_cnt <= stop_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The final stop decision is folded in directly since it is not yet registered.
  always_comb begin
    push_flags            = '0;
    push_flags.parity_err = perr_q;
    push_flags.frame_err  = ferr_q | ~bit_val;
  end

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({shreg, push_flags}),
    .ready (out_ready),
    .valid (out_valid),
    .head  (head),
    .count (fifo_count),
    .drop  (overrun)
  );

  assign head_flags     = rx_flags_t'(head[FLAGS_W-1:0]);
  assign out_data       = head[FW-1:FLAGS_W];
  assign out_parity_err = head_flags.parity_err;
  assign out_frame_err  = head_flags.frame_err;

endmodule
